// File: rtl/wb_pkg.sv
// wb_pkg: shared types and constants for the DDR3 write buffer.
// A beat is four 32-bit pixels with pixel 0 in the low bits.
package wb_pkg;
  localparam int BEAT_W       = 128;
  localparam int PIX_W        = 32;
  localparam int PIX_PER_BEAT = 4;

  typedef logic [BEAT_W-1:0] beat_t;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DONE
  } state_e;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous beat FIFO with first-word fall-through read.
// Push while full and pop while empty are ignored.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   iCLK,
  input  logic                   iRST,
  input  logic                   push,
  input  beat_t                  wdata,
  input  logic                   pop,
  output beat_t                  rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  beat_t         mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full    = cnt_q == FULL_CNT;
  assign empty   = cnt_q == '0;
  assign count   = cnt_q;
  assign rdata   = mem_q[rp_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer and occupancy update; push and pop may coincide.
  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (do_push) wp_d = wp_q + 1'b1;
    if (do_pop)  rp_d = rp_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer registers.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage; contents are don't-care until written.
  always_ff @(posedge iCLK) begin
    if (do_push) mem_q[wp_q] <= wdata;
  end
endmodule

// File: rtl/write_buffer.sv
// write_buffer: packs ALU pixels into 128-bit beats and writes them to DDR3.
// Optional halo crop is enabled by defining WRITE_BUFFER_CROP_EN.
module write_buffer
  import wb_pkg::*;
#(
  parameter int ADDR_W     = 26,
  parameter int FIFO_DEPTH = 16,
  parameter int MAX_DIM    = 512
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_address,
  input  logic [15:0]       width,
  input  logic [15:0]       rows,
`ifdef WRITE_BUFFER_CROP_EN
  input  logic              crop,
`endif
  output logic              ready,
  output logic              done,
  input  logic              pix_valid,
  input  logic [PIX_W-1:0]  pix_data,
  output logic              pix_ready,
  input  logic              local_init_done,
  output logic [ADDR_W-1:0] avl_address,
  output logic              avl_write,
  output logic              avl_read,
  output logic              avl_burstbegin,
  output logic [BEAT_W-1:0] avl_writedata,
  input  logic              avl_wait_request_n
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_q, wr_d;
  beat_t             wdata_q, wdata_d;
  beat_t             pack_q, pack_d;
  logic [1:0]        lane_q, lane_d;
  logic [31:0]       tot_pix_q, tot_pix_d;
  logic [31:0]       pix_cnt_q, pix_cnt_d;
  logic [31:0]       tot_beat_q, tot_beat_d;
  logic [31:0]       beat_cnt_q, beat_cnt_d;
`ifdef WRITE_BUFFER_CROP_EN
  logic              crop_q, crop_d;
  logic [15:0]       w_q, w_d, r_q, r_d;
  logic [15:0]       col_q, col_d, row_q, row_d;
`endif

  logic [15:0]       out_w_c, out_r_c;
  logic [31:0]       pix_c, beat_c;
  logic              accept, keep, push, pop;
  logic              full, empty, beat_ack, last_beat;
  beat_t             push_data, fifo_rdata;
  logic [CW-1:0]     fifo_count;

  // Frame size and transfer lengths for a new request.
  always_comb begin
    out_w_c = width;
    out_r_c = rows;
    pix_c   = {16'd0, width} * {16'd0, rows};
`ifdef WRITE_BUFFER_CROP_EN
    if (crop) begin
      if (width < 16'd3 || rows < 16'd3) begin
        out_w_c = '0;
        out_r_c = '0;
        pix_c   = '0;
      end else begin
        out_w_c = width - 16'd2;
        out_r_c = rows - 16'd2;
      end
    end
`endif
    beat_c = ({16'd0, out_w_c} * {16'd0, out_r_c}) >> 2;
  end

`ifdef WRITE_BUFFER_CROP_EN
  assign keep = !crop_q ||
                (row_q != 16'd0 && row_q != r_q - 16'd1 &&
                 col_q != 16'd0 && col_q != w_q - 16'd1);
`else
  assign keep = 1'b1;
`endif

  assign pix_ready = (state_q == ACTIVE) && !full &&
                     (pix_cnt_q < tot_pix_q);
  assign accept    = pix_valid && pix_ready;
  assign push      = accept && keep && (lane_q == 2'd3);
  assign pop       = (state_q == ACTIVE) && !wr_q && !empty;
  assign beat_ack  = wr_q && avl_wait_request_n;
  assign last_beat = beat_ack && (beat_cnt_q + 32'd1 == tot_beat_q);

  // Current pixel merged into the beat under construction.
  always_comb begin
    push_data = pack_q;
    push_data[{lane_q, 5'd0} +: PIX_W] = pix_data;
  end

  wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .iCLK  (iCLK),
    .iRST  (iRST),
    .push  (push),
    .wdata (push_data),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  // Control FSM, packer and drainer next state.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wr_d       = wr_q;
    wdata_d    = wdata_q;
    pack_d     = pack_q;
    lane_d     = lane_q;
    tot_pix_d  = tot_pix_q;
    pix_cnt_d  = pix_cnt_q;
    tot_beat_d = tot_beat_q;
    beat_cnt_d = beat_cnt_q;
`ifdef WRITE_BUFFER_CROP_EN
    crop_d = crop_q;
    w_d    = w_q;
    r_d    = r_q;
    col_d  = col_q;
    row_d  = row_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start && local_init_done) begin
          state_d    = ACTIVE;
          addr_d     = start_address;
          tot_pix_d  = pix_c;
          tot_beat_d = beat_c;
          pix_cnt_d  = '0;
          beat_cnt_d = '0;
          pack_d     = '0;
          lane_d     = '0;
`ifdef WRITE_BUFFER_CROP_EN
          crop_d = crop;
          w_d    = width;
          r_d    = rows;
          col_d  = '0;
          row_d  = '0;
`endif
        end
      end
      ACTIVE: begin
        if (accept) begin
          pix_cnt_d = pix_cnt_q + 32'd1;
          if (keep) begin
            lane_d = lane_q + 2'd1;
            pack_d = (lane_q == 2'd3) ? '0 : push_data;
          end
`ifdef WRITE_BUFFER_CROP_EN
          if (col_q == w_q - 16'd1) begin
            col_d = '0;
            row_d = row_q + 16'd1;
          end else begin
            col_d = col_q + 16'd1;
          end
`endif
        end
        if (beat_ack) begin
          wr_d       = 1'b0;
          addr_d     = addr_q + 1'b1;
          beat_cnt_d = beat_cnt_q + 32'd1;
        end else if (pop) begin
          wr_d    = 1'b1;
          wdata_d = fifo_rdata;
        end
        if (tot_beat_q == '0 || last_beat) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wr_q       <= 1'b0;
      wdata_q    <= '0;
      pack_q     <= '0;
      lane_q     <= '0;
      tot_pix_q  <= '0;
      pix_cnt_q  <= '0;
      tot_beat_q <= '0;
      beat_cnt_q <= '0;
`ifdef WRITE_BUFFER_CROP_EN
      crop_q <= 1'b0;
      w_q    <= '0;
      r_q    <= '0;
      col_q  <= '0;
      row_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wr_q       <= wr_d;
      wdata_q    <= wdata_d;
      pack_q     <= pack_d;
      lane_q     <= lane_d;
      tot_pix_q  <= tot_pix_d;
      pix_cnt_q  <= pix_cnt_d;
      tot_beat_q <= tot_beat_d;
      beat_cnt_q <= beat_cnt_d;
`ifdef WRITE_BUFFER_CROP_EN
      crop_q <= crop_d;
      w_q    <= w_d;
      r_q    <= r_d;
      col_q  <= col_d;
      row_q  <= row_d;
`endif
    end
  end

  assign ready          = (state_q == IDLE) && local_init_done;
  assign done           = state_q == DONE;
  assign avl_address    = addr_q;
  assign avl_write      = wr_q;
  assign avl_read       = 1'b0;
  assign avl_burstbegin = avl_write || avl_read;
  assign avl_writedata  = wdata_q;

  // Accepted frames must pack into whole beats and stay in range.
  a_dims: assert property (@(posedge iCLK) disable iff (iRST)
    (start && ready) |->
      (out_w_c[1:0] == 2'b00 &&
       {16'd0, width} <= 32'(MAX_DIM) &&
       {16'd0, rows} <= 32'(MAX_DIM)));

  // Pixel gating must keep the FIFO from overfilling.
  a_fifo: assert property (@(posedge iCLK) disable iff (iRST)
    fifo_count <= CW'(FIFO_DEPTH));
endmodule

// File: tb/tb_write_buffer.sv
// tb_write_buffer: self-checking bench for write_buffer.
// Table-driven and random frames compared against a frame-level model.
module tb_write_buffer;
  localparam int AW = 26;

  logic          iCLK = 1'b0;
  logic          iRST;
  logic          start;
  logic [AW-1:0] start_address;
  logic [15:0]   width, rows;
`ifdef WRITE_BUFFER_CROP_EN
  logic          crop_i;
`endif
  logic          ready, done;
  logic          pix_valid;
  logic [31:0]   pix_data;
  logic          pix_ready;
  logic          local_init_done;
  logic [AW-1:0] avl_address;
  logic          avl_write, avl_read, avl_burstbegin;
  logic [127:0]  avl_writedata;
  logic          avl_wait_request_n;

  always #5 iCLK = ~iCLK;

  write_buffer #(
    .ADDR_W     (AW),
    .FIFO_DEPTH (2),
    .MAX_DIM    (512)
  ) dut (
    .iCLK               (iCLK),
    .iRST               (iRST),
    .start              (start),
    .start_address      (start_address),
    .width              (width),
    .rows               (rows),
`ifdef WRITE_BUFFER_CROP_EN
    .crop               (crop_i),
`endif
    .ready              (ready),
    .done               (done),
    .pix_valid          (pix_valid),
    .pix_data           (pix_data),
    .pix_ready          (pix_ready),
    .local_init_done    (local_init_done),
    .avl_address        (avl_address),
    .avl_write          (avl_write),
    .avl_read           (avl_read),
    .avl_burstbegin     (avl_burstbegin),
    .avl_writedata      (avl_writedata),
    .avl_wait_request_n (avl_wait_request_n)
  );

  typedef struct {
    int          w;
    int          r;
    logic [AW-1:0] a;
    int          bpm;
    int          vm;
    int          seq;
    int          exp_b;
  } vec_t;

  vec_t tbl[6];

  int checks = 0;
  int errors = 0;

  logic [31:0]   pix_mem [4096];
  logic [31:0]   kept [$];
  logic [AW-1:0] exp_a [$];
  logic [127:0]  exp_d [$];
  logic [AW-1:0] got_a [$];
  logic [127:0]  got_d [$];

  int pix_idx, n_pix, done_cnt, done_tick, tick_no;
  int wr_cycles, bp_cnt, bp_mode, v_mode;
  logic prev_stall;
  logic [AW-1:0] prev_a;
  logic [127:0] prev_d;
  logic last_ready, last_done, last_wr, last_pix_ready;
  logic last_rd, last_bb;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  // Sample mid-cycle, then drive the next cycle's inputs after the edge.
  task automatic tick();
    @(negedge iCLK);
    if (prev_stall) begin
      checks++;
      if (avl_address !== prev_a || avl_writedata !== prev_d) begin
        errors++;
        $display("FAIL hold addr %0h/%0h data %0h/%0h",
                 avl_address, prev_a, avl_writedata, prev_d);
      end
    end
    prev_stall     = avl_write && !avl_wait_request_n;
    prev_a         = avl_address;
    prev_d         = avl_writedata;
    last_ready     = ready;
    last_done      = done;
    last_wr        = avl_write;
    last_pix_ready = pix_ready;
    last_rd        = avl_read;
    last_bb        = avl_burstbegin;
    if (pix_valid && pix_ready) pix_idx++;
    if (avl_write) begin
      wr_cycles++;
      if (!avl_wait_request_n) bp_cnt++;
    end
    if (avl_write && avl_wait_request_n) begin
      got_a.push_back(avl_address);
      got_d.push_back(avl_writedata);
      bp_cnt = 0;
      chk("burstbegin", avl_burstbegin, 1);
    end
    if (done) begin
      done_cnt++;
      done_tick = tick_no;
    end
    tick_no++;
    @(posedge iCLK);
    #1;
    pix_valid = (pix_idx < n_pix) &&
                (v_mode == 0 || $urandom_range(0, 2) != 0);
    pix_data  = (pix_idx < n_pix) ? pix_mem[pix_idx] : 32'hDEAD_0000;
    case (bp_mode)
      1:       avl_wait_request_n = bp_cnt >= 5;
      2:       avl_wait_request_n = tick_no >= 40;
      3:       avl_wait_request_n = 1'($urandom_range(0, 1));
      default: avl_wait_request_n = 1'b1;
    endcase
  endtask

  task automatic clear_stats();
    pix_idx    = 0;
    n_pix      = 0;
    got_a.delete();
    got_d.delete();
    done_cnt   = 0;
    done_tick  = -1;
    wr_cycles  = 0;
    bp_cnt     = 0;
    prev_stall = 1'b0;
    tick_no    = 0;
  endtask

  // Build the expected beat list from the frame, then issue start.
  task automatic prep_xfer(input int w, input int r, input logic [AW-1:0] a,
                           input int cr, input int bpm, input int vm,
                           input int seq);
    int np;
    np = (cr != 0 && (w < 3 || r < 3)) ? 0 : w * r;
    for (int i = 0; i < w * r; i++)
      pix_mem[i] = (seq != 0) ? 32'(i) : $urandom;
    kept.delete();
    exp_a.delete();
    exp_d.delete();
    if (np != 0) begin
      for (int y = 0; y < r; y++)
        for (int x = 0; x < w; x++)
          if (cr == 0 || (y != 0 && y != r - 1 && x != 0 && x != w - 1))
            kept.push_back(pix_mem[y * w + x]);
    end
    for (int b = 0; b < kept.size() / 4; b++) begin
      exp_a.push_back(a + AW'(b));
      exp_d.push_back({kept[4*b+3], kept[4*b+2], kept[4*b+1], kept[4*b]});
    end
    clear_stats();
    n_pix         = np;
    bp_mode       = bpm;
    v_mode        = vm;
    start         = 1'b1;
    start_address = a;
    width         = 16'(w);
    rows          = 16'(r);
`ifdef WRITE_BUFFER_CROP_EN
    crop_i = (cr != 0);
`endif
    tick();
    chk("start_ready", last_ready, 1);
    start = 1'b0;
  endtask

  task automatic finish_xfer(input int id, input int bpm, input int exp_b);
    int cyc;
    cyc = 0;
    while (done_cnt == 0 && cyc < 3000) begin
      tick();
      cyc++;
      if (bpm == 2 && tick_no == 36) begin
        chk($sformatf("x%0d_full_pix", id), pix_idx, 12);
        chk($sformatf("x%0d_full_rdy", id), last_pix_ready, 0);
      end
    end
    if (done_cnt == 0) chk($sformatf("x%0d_timeout", id), 0, 1);
    tick();
    chk($sformatf("x%0d_ready_after", id), last_ready, 1);
    chk($sformatf("x%0d_done_cnt", id), done_cnt, 1);
    chk($sformatf("x%0d_beats", id), got_a.size(), exp_b);
    chk($sformatf("x%0d_model_beats", id), exp_a.size(), exp_b);
    for (int b = 0; b < exp_a.size(); b++) begin
      if (b < got_a.size()) begin
        chk($sformatf("x%0d_addr%0d", id, b), got_a[b], exp_a[b]);
        chk($sformatf("x%0d_data%0d", id, b), got_d[b], exp_d[b]);
      end
    end
    chk($sformatf("x%0d_pix_used", id), pix_idx, n_pix);
    if (exp_b == 0) begin
      chk($sformatf("x%0d_no_write", id), wr_cycles, 0);
      chk($sformatf("x%0d_done_tick", id), done_tick, 2);
    end
    if (bpm == 1) chk($sformatf("x%0d_wr_cycles", id), wr_cycles, 6 * exp_b);
  endtask

  task automatic run_xfer(input int id, input int w, input int r,
                          input logic [AW-1:0] a, input int cr,
                          input int bpm, input int vm, input int seq,
                          input int exp_b);
    prep_xfer(w, r, a, cr, bpm, vm, seq);
    finish_xfer(id, bpm, exp_b);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int w, r;
    tbl[0] = '{w: 8,  r: 2, a: 26'h100, bpm: 0, vm: 0, seq: 1, exp_b: 4};
    tbl[1] = '{w: 8,  r: 2, a: 26'h100, bpm: 1, vm: 0, seq: 1, exp_b: 4};
    tbl[2] = '{w: 16, r: 4, a: 26'h200, bpm: 2, vm: 0, seq: 0, exp_b: 16};
    tbl[3] = '{w: 0,  r: 5, a: 26'h300, bpm: 0, vm: 0, seq: 0, exp_b: 0};
    tbl[4] = '{w: 4,  r: 0, a: 26'h310, bpm: 0, vm: 0, seq: 0, exp_b: 0};
    tbl[5] = '{w: 4,  r: 1, a: 26'h3FFFFFF, bpm: 3, vm: 1, seq: 0, exp_b: 1};

    iRST               = 1'b1;
    start              = 1'b0;
    start_address      = '0;
    width              = '0;
    rows               = '0;
`ifdef WRITE_BUFFER_CROP_EN
    crop_i             = 1'b0;
`endif
    pix_valid          = 1'b0;
    pix_data           = '0;
    local_init_done    = 1'b1;
    avl_wait_request_n = 1'b1;
    bp_mode            = 0;
    v_mode             = 0;
    clear_stats();

    tick();
    tick();
    chk("rst_ready", last_ready, 1);
    chk("rst_done", last_done, 0);
    chk("rst_write", last_wr, 0);
    chk("rst_read", last_rd, 0);
    chk("rst_bb", last_bb, 0);
    chk("rst_addr", prev_a, 0);
    chk("rst_data", prev_d, 0);
    chk("rst_pix_ready", last_pix_ready, 0);
    iRST = 1'b0;
    tick();

    for (int i = 0; i < 6; i++)
      run_xfer(i, tbl[i].w, tbl[i].r, tbl[i].a, 0, tbl[i].bpm,
               tbl[i].vm, tbl[i].seq, tbl[i].exp_b);

    // Start before calibration completes must be dropped.
    clear_stats();
    bp_mode         = 0;
    v_mode          = 0;
    local_init_done = 1'b0;
    for (int i = 0; i < 16; i++) pix_mem[i] = 32'(i);
    n_pix         = 16;
    start         = 1'b1;
    start_address = 26'h5;
    width         = 16'd8;
    rows          = 16'd2;
    tick();
    chk("gate_ready0", last_ready, 0);
    start = 1'b0;
    repeat (8) tick();
    chk("gate_pix", pix_idx, 0);
    local_init_done = 1'b1;
    n_pix = 0;
    repeat (4) tick();
    chk("gate_ready1", last_ready, 1);
    chk("gate_no_write", wr_cycles, 0);
    chk("gate_no_done", done_cnt, 0);

    // Reset after the first of four beats abandons the transfer.
    prep_xfer(8, 2, 26'h40, 0, 0, 0, 1);
    cyc = 0;
    while (got_a.size() < 1 && cyc < 200) begin
      tick();
      cyc++;
    end
    chk("rst_mid_beat1", got_a.size(), 1);
    iRST = 1'b1;
    tick();
    iRST  = 1'b0;
    n_pix = 0;
    tick();
    chk("rst_mid_write", last_wr, 0);
    chk("rst_mid_ready", last_ready, 1);
    repeat (10) tick();
    chk("rst_mid_no_done", done_cnt, 0);
    chk("rst_mid_no_more", got_a.size(), 1);

    // New start after reset, crossing the address wrap.
    run_xfer(7, 8, 2, 26'h3FFFFFE, 0, 0, 0, 1, 4);

    for (int t = 0; t < 6; t++) begin
      w = 4 * $urandom_range(0, 8);
      r = $urandom_range(0, 6);
      run_xfer(10 + t, w, r, AW'($urandom), 0, 3, 1, 0, w * r / 4);
    end

`ifdef WRITE_BUFFER_CROP_EN
    run_xfer(20, 6, 3, 26'h80, 1, 0, 0, 1, 1);
    chk("crop_beat", got_d.size() > 0 ? got_d[0] : '0,
        {32'd10, 32'd9, 32'd8, 32'd7});
    run_xfer(21, 2, 5, 26'h90, 1, 0, 0, 1, 0);
    run_xfer(22, 10, 4, 26'hA0, 1, 3, 1, 0, 4);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/write_buffer.md
Name: write_buffer

Overview:
- Write-direction counterpart of the DDR3 read path.
- Accepts the ALU's result pixel stream (one 32-bit word per cycle) and packs four pixels into each 128-bit beat.
- Buffers beats in a small FIFO and drains them to consecutive DDR3 addresses as an Avalon-MM write master.
- Sits between the ALU output and the DDR3 controller, under top-level control via start/ready/done.

Parameters:
- ADDR_W, 26, width of the DDR3 beat address.
- FIFO_DEPTH, 16, beat FIFO depth (power of two, ≥2).
- MAX_DIM, 512, largest legal width/rows value.

Ports:
- iCLK  in  1  system clock.
- iRST  in  1  synchronous active-high reset.
- start  in  1  single-cycle request; sampled only when ready=1.
- start_address  in  ADDR_W  first beat address.
- width  in  16  input frame width in pixels.
- rows  in  16  input frame height in pixels.
- ready  out  1  idle and accepting start.
- done  out  1  one-cycle pulse after the last beat is accepted by DDR3.
- pix_valid  in  1  pixel present.
- pix_data  in  32  pixel word.
- pix_ready  out  1  pixel accepted when pix_valid&&pix_ready.
- local_init_done  in  1  DDR3 calibration complete.
- avl_address  out  ADDR_W  beat address.
- avl_write  out  1  write request.
- avl_read  out  1  tied 0.
- avl_burstbegin  out  1  equals avl_write||avl_read.
- avl_writedata  out  128  beat data.
- avl_wait_request_n  in  1  slave accepts when high.

Behaviour:
- Reset: state=IDLE, ready=1, done=0, avl_write=0, avl_address=0, avl_writedata=0, FIFO empty, packer cleared, all counters cleared. Reset mid-operation abandons the transfer: avl_write is low the next cycle and no done pulse is produced.
- FSM states:
  - IDLE: ready=local_init_done. start && local_init_done latches address, out_w, out_rows and total_beats = out_w*out_rows/4, then moves to ACTIVE. start while not ready is ignored.
  - ACTIVE: packing and draining run concurrently. Leaves to DONE in the cycle the final beat handshake occurs.
  - DONE: done=1 for exactly one cycle; next state IDLE, where ready=1.
- Output dimensions without the feature: out_w=width, out_rows=rows. out_w must be a multiple of 4; otherwise behaviour is undefined (checked by assertion).
- Zero-size transfer (width=0 or rows=0): ACTIVE lasts one cycle, then DONE. No avl_write is issued.
- Packer:
  - Pixel k of a beat occupies bits [32k+31:32k], k=0 first.
  - On the 4th accepted pixel, the beat is pushed to the FIFO in the same cycle.
  - pix_ready = (state==ACTIVE) && !fifo_full && (pixels_accepted < total_pixels). pix_ready is registered-state derived and has no combinational path from pix_valid.
- Drainer:
  - When !avl_write and FIFO non-empty: pop the FIFO, drive avl_writedata, and set avl_write=1 on the next cycle.
  - avl_address and avl_writedata hold stable while avl_write && !avl_wait_request_n.
  - On avl_write && avl_wait_request_n: beat complete, avl_address += 1, beats_written += 1, and avl_write drops for at least one cycle.
  - Throughput: one beat per two cycles minimum.
- FIFO:
  - Push is blocked only via pix_ready.
  - Simultaneous push and pop is legal, including at full-minus-one and empty-plus-one.
  - Overflow is impossible by construction.
- Address arithmetic wraps modulo 2^ADDR_W.

Optional Feature:
- Macro: WRITE_BUFFER_CROP_EN.
- With it defined: adds input crop (1 bit). When crop=1 at start, the 1-pixel halo added by padded reads is discarded:
  - Input pixels in row 0, row rows-1, column 0 or column width-1 are accepted but not packed.
  - out_w=width-2, out_rows=rows-2.
  - Column and row counters track input position.
  - width<3 or rows<3 is treated as a zero-size transfer.
- Without it: no crop port, and every accepted pixel is packed.

Decomposition:
- Package wb_pkg:
  - state enum (IDLE, ACTIVE, DONE).
  - BEAT_W=128, PIX_W=32, PIX_PER_BEAT=4.
  - beat_t typedef.
- Sub-module: wb_fifo, a synchronous beat_t FIFO with push/pop/full/empty/count, reset by iRST.

Test Plan:
- Basic transfer: width=8, rows=2, start_address=0x100, pixels 0..15, wait_request_n=1 → 4 writes to 0x100..0x103. Beat 0 = {3,2,1,0} (pixel 0 in LSBs). done pulses once; ready returns to 1.
- Backpressure: same frame, wait_request_n low 5 cycles on each beat → address and data held stable, identical 4 beats, no lost or duplicate beats.
- FIFO full: FIFO_DEPTH=2, wait_request_n=0 for 40 cycles, width=16, rows=4 → pix_ready drops after 12 pixels accepted. Releasing backpressure completes all 16 beats in order.
- Start gating: start while local_init_done=0 → ignored, no writes. width=0 → done 2 cycles after start, avl_write never asserted.
- Reset mid-operation: iRST asserted after beat 1 of 4 → avl_write=0 next cycle, ready=1, no done. A new start then writes from its own start_address.
- Crop (with WRITE_BUFFER_CROP_EN): width=6, rows=3, crop=1, pixels 0..17 → single beat {10,9,8,7} written.
